capture_sequencer: RTL and testbench

- Sys_clk-domain controller that sequences the analyzer's capture buffer using the save/output trigger pulses from the function-key front end.
- On a save trigger it arms, waits for start-of-packet, and writes the decoded DSI byte stream into an external single-port-write/single-port-read BRAM until the buffer is full or the next packet starts.
- On an output trigger it replays the captured words to a valid/ready stream (UART/host link) at one word per cycle, absorbing the BRAM's 1-cycle read latency.

---
 rtl/capture_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_capture_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Capture sequencer: arms on a save trigger, records one DSI packet into an
// external BRAM, and replays the stored words to a valid/ready stream.
module capture_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              trigger_save_data,
    input  logic              trigger_output_data,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [ADDR_W:0]   capture_len,
    output logic [1:0]        state_led,
    output logic              busy
);

    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE,
        S_OUTPUT
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W:0]   wcount;
    logic [ADDR_W:0]   raddr;
    logic [ADDR_W:0]   cap_len;
    logic              wr_en;
    logic              rd_en;
    logic              rd_inflight;
    logic              rd_last_inflight;
    logic              pop;
    logic [1:0]        fifo_cnt;
    logic [2:0]        credit;
    logic [DATA_W-1:0] f0_d, f1_d;
    logic              f0_l, f1_l;

    assign pop = out_valid & out_ready;

    // Read credit counts the word leaving this cycle so a full-rate stream
    // keeps one read in flight while the FIFO head is being consumed.
    assign credit = 3'(fifo_cnt) - 3'(pop) + 3'(rd_inflight);

    // Next-state and BRAM strobe decode
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger_save_data) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (in_valid && in_sof) begin
                    wr_en     = 1'b1;
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (in_valid) begin
                    if (in_sof) begin
                        state_nxt = S_DONE;
                    end else begin
                        wr_en = 1'b1;
                        if (wcount == LAST_ADDR) state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (trigger_save_data) state_nxt = S_ARMED;
                else if (trigger_output_data && (cap_len != '0)) state_nxt = S_OUTPUT;
            end
            S_OUTPUT: begin
                rd_en = (credit < 3'd2) && (raddr < cap_len);
                if (pop && out_last) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Write pointer and captured length
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wcount  <= '0;
            cap_len <= '0;
        end else begin
            if (state != S_ARMED && state_nxt == S_ARMED) begin
                wcount  <= '0;
                cap_len <= '0;
            end else if (wr_en) begin
                wcount <= wcount + 1'b1;
            end
            if (state == S_CAPTURE && state_nxt == S_DONE)
                cap_len <= wr_en ? wcount + 1'b1 : wcount;
        end
    end

    // Read pointer and in-flight read tracking (BRAM latency is one cycle)
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            raddr            <= '0;
            rd_inflight      <= 1'b0;
            rd_last_inflight <= 1'b0;
        end else begin
            if (state != S_OUTPUT && state_nxt == S_OUTPUT) raddr <= '0;
            else if (rd_en)                                raddr <= raddr + 1'b1;
            rd_inflight      <= rd_en;
            rd_last_inflight <= rd_en && (raddr == cap_len - 1'b1);
        end
    end

    // Two-entry prefetch FIFO; entry 0 is the head driving out_*
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fifo_cnt <= '0;
            f0_d     <= '0;
            f1_d     <= '0;
            f0_l     <= 1'b0;
            f1_l     <= 1'b0;
        end else begin
            if (pop) begin
                f0_d <= f1_d;
                f0_l <= f1_l;
            end
            if (rd_inflight) begin
                if ((fifo_cnt - 2'(pop)) == 2'd0) begin
                    f0_d <= ram_rdata;
                    f0_l <= rd_last_inflight;
                end else begin
                    f1_d <= ram_rdata;
                    f1_l <= rd_last_inflight;
                end
            end
            fifo_cnt <= fifo_cnt - 2'(pop) + 2'(rd_inflight);
        end
    end

    // Status outputs
    always_comb begin
        state_led = 2'd0;
        busy      = 1'b0;
        case (state)
            S_IDLE:    state_led = 2'd0;
            S_ARMED:   begin state_led = 2'd1; busy = 1'b1; end
            S_CAPTURE: begin state_led = 2'd2; busy = 1'b1; end
            S_DONE:    state_led = 2'd3;
            S_OUTPUT:  begin state_led = 2'd3; busy = 1'b1; end
            default:   state_led = 2'd0;
        endcase
    end

    assign ram_we      = wr_en;
    assign ram_waddr   = wcount[ADDR_W-1:0];
    assign ram_wdata   = wr_en ? in_data : '0;
    assign ram_re      = rd_en;
    assign ram_raddr   = raddr[ADDR_W-1:0];
    assign out_valid   = (fifo_cnt != 2'd0);
    assign out_data    = f0_d;
    assign out_last    = out_valid & f0_l;
    assign capture_len = cap_len;

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer with a small buffer (ADDR_W=4).
module tb_capture_sequencer;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          trigger_save_data, trigger_output_data;
    logic          in_valid, in_sof, out_ready;
    logic [DW-1:0] in_data, ram_wdata, ram_rdata, out_data;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic          ram_we, ram_re, out_valid, out_last, busy;
    logic [AW:0]   capture_len;
    logic [1:0]    state_led;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { logic [DW-1:0] d; logic l; } out_t;

    wr_t           exp_wr[$];
    out_t          exp_out[$];
    logic [DW-1:0] image[$];
    logic [DW-1:0] mem[DEPTH];

    bit wr_chk  = 0;
    bit bp_mode = 0;
    int issued = 0, xfer = 0;
    int first_re = -1, first_ov = -1, last_xfer = -1;
    bit prev_stall = 0;
    logic [DW-1:0] prev_d;
    logic          prev_l;

    capture_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .trigger_save_data(trigger_save_data), .trigger_output_data(trigger_output_data),
        .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .capture_len(capture_len), .state_led(state_led), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Cycle counter
    always @(posedge sys_clk) cyc <= cyc + 1;

    // External BRAM: synchronous write, one-cycle read latency
    always @(posedge sys_clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: writes, read pacing, output transfers and stall stability
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (ram_we && wr_chk) begin
                if (exp_wr.size() == 0) check("unexpected_write", 32'(ram_waddr), 32'hFFFF);
                else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("write_addr", 32'(ram_waddr), 32'(w.a));
                    check("write_data", 32'(ram_wdata), 32'(w.d));
                end
            end
            if (ram_re) begin
                issued++;
                if (first_re < 0) first_re = cyc;
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (prev_stall) begin
                check("stall_valid_held", 32'(out_valid), 1);
                check("stall_data_held", 32'(out_data), 32'(prev_d));
                check("stall_last_held", 32'(out_last), 32'(prev_l));
            end
            if (out_valid && out_ready) begin
                xfer++;
                last_xfer = cyc;
                if (exp_out.size() == 0) check("unexpected_output", 32'(out_data), 32'hFFFF);
                else begin
                    out_t o;
                    o = exp_out.pop_front();
                    check("out_data", 32'(out_data), 32'(o.d));
                    check("out_last", 32'(out_last), 32'(o.l));
                end
            end
            if (ram_re) check("reads_outstanding_le2", 32'((issued - xfer) <= 2), 1);
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
        end else begin
            prev_stall = 0;
        end
    end

    // Random downstream backpressure
    initial begin
        forever begin
            @(posedge sys_clk);
            #2;
            if (bp_mode) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ram_we"}, 32'(ram_we), 0);
        check({tag, "_ram_re"}, 32'(ram_re), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_last"}, 32'(out_last), 0);
        check({tag, "_capture_len"}, 32'(capture_len), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_state_led"}, 32'(state_led), 0);
    endtask

    // Build a word stream, derive expected writes from the packet rules, drive it.
    task automatic capture(input bit do_trig, input int njunk, input int nbody, input bit term,
                           input bit gaps, input bit fixed, input int otrig);
        logic [DW-1:0] sd[$];
        bit            ss[$];
        bit            started;
        for (int i = 0; i < njunk; i++) begin sd.push_back(DW'($urandom)); ss.push_back(0); end
        sd.push_back(fixed ? 8'h0F : DW'($urandom)); ss.push_back(1);
        for (int i = 0; i < nbody; i++) begin
            sd.push_back(fixed ? 8'(8'h10 + i) : DW'($urandom));
            ss.push_back(0);
        end
        if (term) begin sd.push_back(8'hAA); ss.push_back(1); end

        image.delete();
        started = 0;
        foreach (sd[i]) begin
            if (!started) begin
                if (ss[i]) begin started = 1; image.push_back(sd[i]); end
            end else if (image.size() == DEPTH || ss[i]) begin
                break;
            end else begin
                image.push_back(sd[i]);
            end
        end
        foreach (image[i]) begin
            wr_t w;
            w.a = AW'(i);
            w.d = image[i];
            exp_wr.push_back(w);
        end

        if (do_trig) begin
            trigger_save_data = 1; tick(); trigger_save_data = 0;
            check("armed_state", 32'(state_led), 1);
            check("armed_busy", 32'(busy), 1);
        end
        foreach (sd[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 0; in_sof = 1'($urandom_range(0, 1)); in_data = DW'($urandom);
                tick();
            end
            in_valid = 1; in_data = sd[i]; in_sof = ss[i];
            if (i == otrig) trigger_output_data = 1;
            tick();
            trigger_output_data = 0;
            if (i == otrig) begin
                check("out_trig_in_capture_state", 32'(state_led), 2);
                check("out_trig_in_capture_no_read", 32'(ram_re), 0);
            end
        end
        in_valid = 0; in_sof = 0;
        tick(2);
        check("writes_complete", 32'(exp_wr.size()), 0);
        check("capture_len", 32'(capture_len), 32'(image.size()));
        check("done_state", 32'(state_led), 3);
        check("done_not_busy", 32'(busy), 0);
    endtask

    task automatic replay(input bit bp);
        int n, trig_cyc;
        n = image.size();
        foreach (image[i]) begin
            out_t o;
            o.d = image[i];
            o.l = (i == n - 1);
            exp_out.push_back(o);
        end
        issued = 0; xfer = 0; first_re = -1; first_ov = -1; last_xfer = -1;
        if (!bp) out_ready = 1;
        bp_mode = bp;
        trigger_output_data = 1;
        trig_cyc = cyc;
        tick();
        trigger_output_data = 0;
        for (int i = 0; i < 400 && exp_out.size() != 0; i++) tick();
        tick();
        check("replay_drained", 32'(exp_out.size()), 0);
        bp_mode = 0;
        out_ready = 1;
        check("replay_end_busy", 32'(busy), 0);
        check("replay_end_valid", 32'(out_valid), 0);
        check("replay_end_state", 32'(state_led), 3);
        check("replay_word_count", 32'(xfer), 32'(n));
        if (!bp) begin
            check("first_read_latency", 32'(first_re - trig_cyc), 1);
            check("first_valid_latency", 32'(first_ov - trig_cyc), 3);
            check("full_rate_span", 32'(last_xfer - first_ov), 32'(n - 1));
        end
        exp_out.delete();
    endtask

    // Hard time limit
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        bit seen;
        sys_rst = 1; trigger_save_data = 0; trigger_output_data = 0;
        in_valid = 0; in_sof = 0; in_data = '0; out_ready = 1;
        tick(3);
        check_zero("reset");
        sys_rst = 0;

        // Reset in the middle of a capture
        trigger_save_data = 1; tick(); trigger_save_data = 0;
        in_valid = 1; in_sof = 1; in_data = 8'h0F; tick();
        in_sof = 0; in_data = 8'h01; tick();
        in_data = 8'h02; tick();
        check("mid_capture_state", 32'(state_led), 2);
        in_data = 8'h03; sys_rst = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_zero("reset_mid_capture");
        end
        in_valid = 0; sys_rst = 0;
        tick();
        trigger_output_data = 1; tick(); trigger_output_data = 0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid || ram_re || busy) seen = 1;
            tick();
        end
        check("idle_out_trig_ignored", 32'(seen), 0);
        check("idle_state_after_trig", 32'(state_led), 0);
        wr_chk = 1;

        // Directed packet: 2 junk, SOF 0x0F, 0x10..0x14, terminating SOF
        capture(1, 2, 5, 1, 0, 1, -1);
        replay(0);
        replay(0);
        replay(1);

        // Save and output together in DONE: save wins
        trigger_save_data = 1; trigger_output_data = 1; tick();
        trigger_save_data = 0; trigger_output_data = 0;
        check("both_trig_armed", 32'(state_led), 1);
        check("both_trig_no_read", 32'(ram_re), 0);
        capture(0, 1, 6, 1, 0, 0, 3);
        replay(0);

        // Full buffer: SOF followed by a 20-word continuous stream
        capture(1, 0, 20, 0, 0, 0, -1);
        replay(0);
        replay(1);

        // Random packets and random backpressure
        for (int k = 0; k < 8; k++) begin
            capture(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 20)), 1, 1, 0, -1);
            replay(1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
